// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Receive-side protocol checker for a four-road intersection
//               controller. Samples the four road lamp buses and the four
//               pedestrian crossing lamp buses every clock and checks code
//               legality, cross-road / pedestrian conflicts, per-bus phase
//               ordering and road dwell timing. Reports registered one-cycle
//               error pulses, a sticky error flag and a saturating count.
//
// Ports       : clk             - system clock, rising edge
//               rst             - synchronous active-high reset
//               rd1_i..rd4_i    - road lamps {red,yellow,green}
//               rd1c_i..rd4c_i  - pedestrian lamp across road N, same code
//               err_encoding_o  - pulse: illegal lamp code sampled
//               err_conflict_o  - pulse: road/pedestrian conflict sampled
//               err_sequence_o  - pulse: illegal phase transition
//               err_timing_o    - pulse: dwell or all-red limit violated
//               err_any_o       - sticky OR of all error pulses
//               err_count_o     - saturating count of cycles with an error
//               active_road_o   - index (0..3) of the last single non-red road
//
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
   parameter int MIN_GREEN   = 4,
   parameter int YELLOW_LEN  = 2,
   parameter int MAX_ALL_RED = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       rd1_i,
   input  logic [2:0]       rd2_i,
   input  logic [2:0]       rd3_i,
   input  logic [2:0]       rd4_i,
   input  logic [2:0]       rd1c_i,
   input  logic [2:0]       rd2c_i,
   input  logic [2:0]       rd3c_i,
   input  logic [2:0]       rd4c_i,
   output logic             err_encoding_o,
   output logic             err_conflict_o,
   output logic             err_sequence_o,
   output logic             err_timing_o,
   output logic             err_any_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [1:0]       active_road_o
);

   localparam logic [2:0]       c_red         = 3'b100;
   localparam logic [2:0]       c_yel         = 3'b010;
   localparam logic [2:0]       c_grn         = 3'b001;
   localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_max     = '1;
   localparam logic [CNT_W-1:0] c_min_green   = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] c_yel_len     = CNT_W'(YELLOW_LEN);
   localparam logic [CNT_W-1:0] c_allred_lim  = CNT_W'(MAX_ALL_RED + 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Buses 0..3 are roads 1..4, buses 4..7 are the matching crossings.
   logic [2:0] w_bus [8];

   assign w_bus[0] = rd1_i;
   assign w_bus[1] = rd2_i;
   assign w_bus[2] = rd3_i;
   assign w_bus[3] = rd4_i;
   assign w_bus[4] = rd1c_i;
   assign w_bus[5] = rd2c_i;
   assign w_bus[6] = rd3c_i;
   assign w_bus[7] = rd4c_i;

   logic       w_run;
   logic [7:0] w_enc_bad;
   logic [7:0] w_seq_bad;
   logic [7:0] w_tim_bad;
   logic [3:0] w_nonred;
   logic [3:0] w_ped_conf;

   assign w_run = (state_q == ST_RUN);

   // -------------------------------------------------------------------------
   // Per-bus legality, transition and (roads only) dwell checks
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < 8; i++) begin : g_bus
      localparam bit c_is_ped = (i >= 4);

      logic [2:0] prev_q;
      logic       w_cur_ok;
      logic       w_prev_ok;
      logic       w_trans_ok;

      assign w_cur_ok  = (w_bus[i] == c_red) || (w_bus[i] == c_yel) || (w_bus[i] == c_grn);
      assign w_prev_ok = (prev_q == c_red) || (prev_q == c_yel) || (prev_q == c_grn);

      always_comb begin
         w_trans_ok = 1'b0;
         if (w_bus[i] == prev_q) begin
            w_trans_ok = 1'b1;
         end else if (prev_q == c_red && w_bus[i] == c_grn) begin
            w_trans_ok = 1'b1;
         end else if (prev_q == c_grn && w_bus[i] == c_yel) begin
            w_trans_ok = 1'b1;
         end else if (prev_q == c_yel && w_bus[i] == c_red) begin
            w_trans_ok = 1'b1;
         end else if (c_is_ped && prev_q == c_grn && w_bus[i] == c_red) begin
            // A crossing may drop straight from walk to don't-walk.
            w_trans_ok = 1'b1;
         end
      end

      assign w_enc_bad[i] = ~w_cur_ok;
      // A transition into or out of an illegal code carries no phase meaning.
      assign w_seq_bad[i] = w_cur_ok & w_prev_ok & ~w_trans_ok;

      always_ff @(posedge clk) begin
         if (rst) begin
            prev_q <= '0;
         end else begin
            prev_q <= w_bus[i];
         end
      end

      if (i < 4) begin : g_dwell
         logic [CNT_W-1:0] dwell_q, dwell_d;
         logic             w_tim;

         always_comb begin
            dwell_d = dwell_q;
            w_tim   = 1'b0;
            if (!w_run) begin
               // The capture sample is the first cycle of the current lamp.
               dwell_d = c_one;
            end else if (w_bus[i] != prev_q) begin
               dwell_d = c_one;
               if (w_cur_ok && w_prev_ok) begin
                  if (prev_q == c_grn && w_bus[i] == c_yel && dwell_q < c_min_green) begin
                     w_tim = 1'b1;
                  end
                  if (prev_q == c_yel && w_bus[i] == c_red && dwell_q != c_yel_len) begin
                     w_tim = 1'b1;
                  end
               end
            end else begin
               if (dwell_q != c_cnt_max) begin
                  dwell_d = dwell_q + c_one;
               end
               // Fires only on the step from YELLOW_LEN to YELLOW_LEN+1.
               if (w_bus[i] == c_yel && dwell_q == c_yel_len) begin
                  w_tim = 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               dwell_q <= '0;
            end else begin
               dwell_q <= dwell_d;
            end
         end

         assign w_tim_bad[i]  = w_tim;
         assign w_nonred[i]   = (w_bus[i] != c_red);
         assign w_ped_conf[i] = (w_bus[i + 4] == c_grn) && (w_bus[i] != c_red);
      end else begin : g_no_dwell
         assign w_tim_bad[i] = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: one capture cycle after reset, then permanent checking
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
      endcase
   end

   // -------------------------------------------------------------------------
   // Conflict, all-red watchdog and aggregation
   // -------------------------------------------------------------------------
   logic             w_multi;
   logic             w_all_red;
   logic             w_allred_hit;
   logic             w_enc;
   logic             w_conf;
   logic             w_seq;
   logic             w_tim;
   logic             w_any;
   logic [CNT_W-1:0] allred_q, allred_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [1:0]       active_road_q, active_road_d;
   logic             err_encoding_q;
   logic             err_conflict_q;
   logic             err_sequence_q;
   logic             err_timing_q;
   logic             err_any_q;

   // More than one bit set: clearing the lowest set bit leaves something.
   assign w_multi   = |(w_nonred & (w_nonred - 4'd1));
   assign w_all_red = (w_nonred == 4'b0000);

   always_comb begin
      allred_d     = allred_q;
      w_allred_hit = 1'b0;
      if (!w_run) begin
         allred_d = w_all_red ? c_one : '0;
      end else if (!w_all_red) begin
         allred_d = '0;
      end else if (allred_q < c_allred_lim) begin
         // Counter parks at MAX_ALL_RED+1 so the pulse cannot repeat.
         allred_d     = allred_q + c_one;
         w_allred_hit = (allred_q == c_allred_lim - c_one);
      end
   end

   assign w_enc = w_run & (|w_enc_bad);
   assign w_conf = w_run & (w_multi | (|w_ped_conf));
   assign w_seq = w_run & (|w_seq_bad);
   assign w_tim = w_run & ((|w_tim_bad) | w_allred_hit);
   assign w_any = w_enc | w_conf | w_seq | w_tim;

   always_comb begin
      err_count_d = err_count_q;
      if (w_any && err_count_q != c_cnt_max) begin
         err_count_d = err_count_q + c_one;
      end
   end

   always_comb begin
      active_road_d = active_road_q;
      case (w_nonred)
         4'b0001: active_road_d = 2'd0;
         4'b0010: active_road_d = 2'd1;
         4'b0100: active_road_d = 2'd2;
         4'b1000: active_road_d = 2'd3;
         default: active_road_d = active_road_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_encoding_q <= 1'b0;
         err_conflict_q <= 1'b0;
         err_sequence_q <= 1'b0;
         err_timing_q   <= 1'b0;
         err_any_q      <= 1'b0;
         err_count_q    <= '0;
         active_road_q  <= 2'd0;
         allred_q       <= '0;
      end else begin
         err_encoding_q <= w_enc;
         err_conflict_q <= w_conf;
         err_sequence_q <= w_seq;
         err_timing_q   <= w_tim;
         err_any_q      <= err_any_q | w_any;
         err_count_q    <= err_count_d;
         active_road_q  <= active_road_d;
         allred_q       <= allred_d;
      end
   end

   assign err_encoding_o = err_encoding_q;
   assign err_conflict_o = err_conflict_q;
   assign err_sequence_o = err_sequence_q;
   assign err_timing_o   = err_timing_q;
   assign err_any_o      = err_any_q;
   assign err_count_o    = err_count_q;
   assign active_road_o  = active_road_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed-stimulus bench for traffic_light_monitor with a
//               behavioural reference model and per-cycle comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

   localparam int MIN_GREEN   = 4;
   localparam int YELLOW_LEN  = 2;
   localparam int MAX_ALL_RED = 8;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] rd [4];
   logic [2:0] pc [4];

   logic             err_encoding;
   logic             err_conflict;
   logic             err_sequence;
   logic             err_timing;
   logic             err_any;
   logic [CNT_W-1:0] err_count;
   logic [1:0]       active_road;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .MIN_GREEN   (MIN_GREEN),
      .YELLOW_LEN  (YELLOW_LEN),
      .MAX_ALL_RED (MAX_ALL_RED),
      .CNT_W       (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rd1_i          (rd[0]),
      .rd2_i          (rd[1]),
      .rd3_i          (rd[2]),
      .rd4_i          (rd[3]),
      .rd1c_i         (pc[0]),
      .rd2c_i         (pc[1]),
      .rd3c_i         (pc[2]),
      .rd4c_i         (pc[3]),
      .err_encoding_o (err_encoding),
      .err_conflict_o (err_conflict),
      .err_sequence_o (err_sequence),
      .err_timing_o   (err_timing),
      .err_any_o      (err_any),
      .err_count_o    (err_count),
      .active_road_o  (active_road)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: plain integer counts of how long each lamp has been
   // seen, how long all roads have been red, and the rules applied directly.
   // ------------------------------------------------------------------------
   logic [2:0] m_prev [8];
   int  m_dwell [4];
   int  m_allred = 0;
   bit  m_init = 1'b1;
   bit  m_enc = 0, m_conf = 0, m_seq = 0, m_tim = 0, m_any = 0;
   int  m_cnt = 0;
   int  m_act = 0;

   function automatic bit legal(input logic [2:0] v);
      return (v == RED) || (v == YEL) || (v == GRN);
   endfunction

   function automatic bit allowed(input logic [2:0] p, input logic [2:0] c, input bit ped);
      if (p == c) return 1'b1;
      if (p == RED && c == GRN) return 1'b1;
      if (p == GRN && c == YEL) return 1'b1;
      if (p == YEL && c == RED) return 1'b1;
      if (ped && p == GRN && c == RED) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin : model
      logic [2:0] cur [8];
      int  nonred;
      int  last;
      bit  e_enc, e_conf, e_seq, e_tim;
      for (int i = 0; i < 4; i++) begin
         cur[i]     = rd[i];
         cur[i + 4] = pc[i];
      end
      if (rst) begin
         m_init = 1'b1;
         m_enc = 0; m_conf = 0; m_seq = 0; m_tim = 0; m_any = 0;
         m_cnt = 0; m_act = 0; m_allred = 0;
         for (int r = 0; r < 4; r++) m_dwell[r] = 0;
      end else begin
         nonred = 0;
         last   = 0;
         for (int r = 0; r < 4; r++) begin
            if (cur[r] != RED) begin
               nonred++;
               last = r;
            end
         end
         if (nonred == 1) m_act = last;
         e_enc = 0; e_conf = 0; e_seq = 0; e_tim = 0;
         if (m_init) begin
            for (int r = 0; r < 4; r++) m_dwell[r] = 1;
            m_allred = (nonred == 0) ? 1 : 0;
            m_init = 1'b0;
         end else begin
            for (int i = 0; i < 8; i++) begin
               if (!legal(cur[i])) e_enc = 1;
               else if (legal(m_prev[i]) && !allowed(m_prev[i], cur[i], i >= 4)) e_seq = 1;
            end
            if (nonred > 1) e_conf = 1;
            for (int r = 0; r < 4; r++)
               if (cur[r + 4] == GRN && cur[r] != RED) e_conf = 1;
            for (int r = 0; r < 4; r++) begin
               if (cur[r] != m_prev[r]) begin
                  if (legal(cur[r]) && legal(m_prev[r])) begin
                     if (m_prev[r] == GRN && cur[r] == YEL && m_dwell[r] < MIN_GREEN) e_tim = 1;
                     if (m_prev[r] == YEL && cur[r] == RED && m_dwell[r] != YELLOW_LEN) e_tim = 1;
                  end
                  m_dwell[r] = 1;
               end else begin
                  m_dwell[r]++;
                  if (cur[r] == YEL && m_dwell[r] == YELLOW_LEN + 1) e_tim = 1;
               end
            end
            if (nonred == 0) begin
               m_allred++;
               if (m_allred == MAX_ALL_RED + 1) e_tim = 1;
            end else begin
               m_allred = 0;
            end
         end
         m_enc  = e_enc;
         m_conf = e_conf;
         m_seq  = e_seq;
         m_tim  = e_tim;
         if (e_enc || e_conf || e_seq || e_tim) begin
            m_any = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
      end
      for (int i = 0; i < 8; i++) m_prev[i] = cur[i];
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("err_encoding", int'(err_encoding), int'(m_enc));
         check("err_conflict", int'(err_conflict), int'(m_conf));
         check("err_sequence", int'(err_sequence), int'(m_seq));
         check("err_timing",   int'(err_timing),   int'(m_tim));
         check("err_any",      int'(err_any),      int'(m_any));
         check("err_count",    int'(err_count),    m_cnt);
         check("active_road",  int'(active_road),  m_act);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic all_red();
      for (int i = 0; i < 4; i++) begin
         rd[i] = RED;
         pc[i] = RED;
      end
   endtask

   task automatic do_reset();
      all_red();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      all_red();
      rst = 1'b1;
      cyc();
      cyc();
      cmp_en = 1'b1;
      check("reset err_any", int'(err_any), 0);
      check("reset err_count", int'(err_count), 0);
      check("reset active_road", int'(active_road), 0);
      rst = 1'b0;

      // Legal rotation: road 1 green from the first sample after reset.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < MIN_GREEN; k++) begin
            rd[r] = GRN;
            if (r > 0 && k == 0) rd[r - 1] = RED;
            cyc();
            if (k == 0) check("legal active_road", int'(active_road), r);
         end
         for (int k = 0; k < YELLOW_LEN; k++) begin
            rd[r] = YEL;
            cyc();
         end
      end
      rd[3] = RED;
      cyc();
      check("legal err_any", int'(err_any), 0);
      check("legal err_count", int'(err_count), 0);
      check("legal active_road end", int'(active_road), 3);

      // Two roads green together.
      do_reset();
      cyc();
      rd[0] = GRN; rd[2] = GRN;
      cyc();
      check("conflict pulse", int'(err_conflict), 1);
      check("conflict err_any", int'(err_any), 1);
      check("conflict err_count", int'(err_count), 1);
      all_red();
      cyc();
      check("conflict one cycle", int'(err_conflict), 0);

      // Illegal code on road 2 for one sample.
      do_reset();
      cyc();
      rd[1] = 3'b011;
      cyc();
      check("encoding pulse", int'(err_encoding), 1);
      check("encoding no sequence", int'(err_sequence), 0);
      rd[1] = RED;
      cyc();
      check("encoding clears", int'(err_encoding), 0);
      check("encoding recover no sequence", int'(err_sequence), 0);

      // Road 4 red to yellow.
      do_reset();
      cyc();
      rd[3] = YEL;
      cyc();
      check("sequence pulse", int'(err_sequence), 1);
      rd[3] = RED;
      cyc();

      // Crossing 1 walks while road 1 is green.
      do_reset();
      cyc();
      rd[0] = GRN; pc[0] = GRN;
      cyc();
      check("ped conflict pulse", int'(err_conflict), 1);
      check("ped no sequence", int'(err_sequence), 0);

      // Green held only 2 samples before yellow.
      do_reset();
      cyc();
      rd[0] = GRN; cyc(); cyc();
      rd[0] = YEL; cyc();
      check("short green timing", int'(err_timing), 1);
      cyc();
      rd[0] = RED; cyc();
      check("yellow ok timing", int'(err_timing), 0);
      check("short green count", int'(err_count), 1);

      // Yellow held too long: single pulse when it overstays, none after.
      do_reset();
      cyc();
      rd[0] = GRN;
      for (int k = 0; k < MIN_GREEN; k++) cyc();
      rd[0] = YEL; cyc(); cyc(); cyc();
      check("long yellow pulse", int'(err_timing), 1);
      cyc();
      check("long yellow no repeat", int'(err_timing), 0);
      rd[0] = RED; cyc();

      // All-red watchdog: nine consecutive all-red samples.
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (k == 8)  check("allred before limit", int'(err_timing), 0);
         if (k == 9)  check("allred pulse", int'(err_timing), 1);
         if (k == 12) check("allred silent", int'(err_timing), 0);
      end
      check("allred count", int'(err_count), 1);
      for (int k = 0; k < 300; k++) cyc();

      // Errors then reset in the middle of activity.
      do_reset();
      cyc();
      rd[0] = GRN; rd[1] = GRN; cyc();
      rd[0] = 3'b011; cyc();
      rd[0] = GRN; cyc();
      check("midreset count before", int'(err_count), 3);
      all_red();
      rst = 1'b1;
      cyc();
      check("midreset err_any", int'(err_any), 0);
      check("midreset err_count", int'(err_count), 0);
      rst = 1'b0;
      cyc();
      check("post reset no error", int'(err_any), 0);
      cyc();
      check("post reset count", int'(err_count), 0);

      // Error count saturation.
      do_reset();
      cyc();
      rd[0] = GRN; rd[1] = GRN;
      for (int k = 0; k < CNT_MAX + 5; k++) cyc();
      check("count saturates", int'(err_count), CNT_MAX);

      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
